// File: rtl/risc_id_stage.sv
// risc_id_stage
// Pipelined RiSC-16 instruction decode stage. Decodes the 16-bit instruction,
// resolves both source operands through EX > MEM > WB forwarding, detects
// load-use hazards against the instruction held in ID/EX, and registers the
// decoded result into the ID/EX pipeline register.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   fetch handshake; in_ready is combinational
//   instr, pc           instruction word and its PC
//   src1_addr/src2_addr register-file read addresses (combinational)
//   src1/src2           register-file read data
//   fwd_{ex,mem,wb}_*   forwarding sources (enable, destination, value)
//   ex_stall            EX cannot accept; ID/EX holds
//   flush               squash the instruction currently in ID
//   out_*               ID/EX register contents presented to EX
module risc_id_stage #(
    parameter int WORD_LEN     = 16,
    parameter int REG_ADDR_LEN = 3,
    parameter int PC_LEN       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [15:0]             instr,
    input  logic [PC_LEN-1:0]       pc,
    output logic [REG_ADDR_LEN-1:0] src1_addr,
    output logic [REG_ADDR_LEN-1:0] src2_addr,
    input  logic [WORD_LEN-1:0]     src1,
    input  logic [WORD_LEN-1:0]     src2,
    input  logic                    fwd_ex_en,
    input  logic                    fwd_mem_en,
    input  logic                    fwd_wb_en,
    input  logic [REG_ADDR_LEN-1:0] fwd_ex_addr,
    input  logic [REG_ADDR_LEN-1:0] fwd_mem_addr,
    input  logic [REG_ADDR_LEN-1:0] fwd_wb_addr,
    input  logic [WORD_LEN-1:0]     fwd_ex_data,
    input  logic [WORD_LEN-1:0]     fwd_mem_data,
    input  logic [WORD_LEN-1:0]     fwd_wb_data,
    input  logic                    ex_stall,
    input  logic                    flush,
    output logic                    out_valid,
    output logic [2:0]              out_op,
    output logic [REG_ADDR_LEN-1:0] out_tgt,
    output logic                    out_wr_en,
    output logic [WORD_LEN-1:0]     outa,
    output logic [WORD_LEN-1:0]     outb,
    output logic [WORD_LEN-1:0]     out_stdata,
    output logic [PC_LEN-1:0]       out_pc
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    localparam logic [REG_ADDR_LEN-1:0] REG_ZERO = {REG_ADDR_LEN{1'b0}};

    logic [2:0]              op_s;
    logic [REG_ADDR_LEN-1:0] rega_s, regb_s, regc_s;
    logic [WORD_LEN-1:0]     sig_imm_s, lui_imm_s;
    logic [WORD_LEN-1:0]     r1_s, r2_s;
    logic [WORD_LEN-1:0]     outa_s, outb_s, stdata_s;
    logic                    wr_en_s;
    logic                    hazard_s;
    logic                    uses_c_s;

    logic                    out_valid_r;
    logic [2:0]              out_op_r;
    logic [REG_ADDR_LEN-1:0] out_tgt_r;
    logic                    out_wr_en_r;
    logic [WORD_LEN-1:0]     outa_r, outb_r, out_stdata_r;
    logic [PC_LEN-1:0]       out_pc_r;

    // Forwarding resolution: r0 is hard zero, then youngest producer wins.
    function automatic logic [WORD_LEN-1:0] resolve(
        input logic [REG_ADDR_LEN-1:0] addr,
        input logic [WORD_LEN-1:0]     rf_data
    );
        logic [WORD_LEN-1:0] val;
        if (addr == REG_ZERO) begin
            val = {WORD_LEN{1'b0}};
        end else if (fwd_ex_en && (fwd_ex_addr == addr)) begin
            val = fwd_ex_data;
        end else if (fwd_mem_en && (fwd_mem_addr == addr)) begin
            val = fwd_mem_data;
        end else if (fwd_wb_en && (fwd_wb_addr == addr)) begin
            val = fwd_wb_data;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    assign op_s      = instr[15:13];
    assign rega_s    = instr[10 +: REG_ADDR_LEN];
    assign regb_s    = instr[7 +: REG_ADDR_LEN];
    assign regc_s    = instr[0 +: REG_ADDR_LEN];
    assign sig_imm_s = {{(WORD_LEN-7){instr[6]}}, instr[6:0]};
    assign lui_imm_s = {instr[9:0], {(WORD_LEN-10){1'b0}}};
    assign uses_c_s  = (op_s == OP_ADD) || (op_s == OP_NAND);

    assign src1_addr = regb_s;
    assign src2_addr = uses_c_s ? regc_s : rega_s;

    // Operand resolution and decode of the EX-facing fields.
    always_comb begin
        r1_s     = resolve(src1_addr, src1);
        r2_s     = resolve(src2_addr, src2);
        outa_s   = (op_s == OP_LUI) ? lui_imm_s : r1_s;
        outb_s   = {WORD_LEN{1'b0}};
        wr_en_s  = 1'b0;
        stdata_s = (src2_addr == rega_s) ? r2_s : {WORD_LEN{1'b0}};
        case (op_s)
            OP_ADD, OP_NAND: begin
                outb_s  = r2_s;
                wr_en_s = 1'b1;
            end
            OP_BEQ: begin
                outb_s  = r2_s;
                wr_en_s = 1'b0;
            end
            OP_ADDI, OP_LW: begin
                outb_s  = sig_imm_s;
                wr_en_s = 1'b1;
            end
            OP_SW: begin
                outb_s  = sig_imm_s;
                wr_en_s = 1'b0;
            end
            OP_LUI, OP_JALR: begin
                outb_s  = {WORD_LEN{1'b0}};
                wr_en_s = 1'b1;
            end
            default: begin
                outb_s  = {WORD_LEN{1'b0}};
                wr_en_s = 1'b0;
            end
        endcase
        if (rega_s == REG_ZERO) begin
            wr_en_s = 1'b0;
        end else begin
            wr_en_s = wr_en_s;
        end
    end

    // Load-use hazard: the LW in ID/EX cannot forward its data until MEM.
    always_comb begin
        hazard_s = 1'b0;
        if (out_valid_r && (out_op_r == OP_LW) && (out_tgt_r != REG_ZERO) && in_valid) begin
            if ((op_s != OP_LUI) && (out_tgt_r == regb_s)) begin
                hazard_s = 1'b1;
            end else if (uses_c_s && (out_tgt_r == regc_s)) begin
                hazard_s = 1'b1;
            end else if (((op_s == OP_SW) || (op_s == OP_BEQ)) && (out_tgt_r == rega_s)) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = 1'b0;
            end
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign in_ready = !ex_stall && !hazard_s && !flush;

    // ID/EX pipeline register: reset > stall hold > flush > bubble > load.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_op_r     <= 3'b000;
            out_tgt_r    <= REG_ZERO;
            out_wr_en_r  <= 1'b0;
            outa_r       <= {WORD_LEN{1'b0}};
            outb_r       <= {WORD_LEN{1'b0}};
            out_stdata_r <= {WORD_LEN{1'b0}};
            out_pc_r     <= {PC_LEN{1'b0}};
        end else if (ex_stall) begin
            out_valid_r  <= out_valid_r;
            out_wr_en_r  <= out_wr_en_r;
        end else if (flush || hazard_s || !in_valid) begin
            out_valid_r  <= 1'b0;
            out_wr_en_r  <= 1'b0;
        end else begin
            out_valid_r  <= 1'b1;
            out_op_r     <= op_s;
            out_tgt_r    <= rega_s;
            out_wr_en_r  <= wr_en_s;
            outa_r       <= outa_s;
            outb_r       <= outb_s;
            out_stdata_r <= stdata_s;
            out_pc_r     <= pc;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_op     = out_op_r;
    assign out_tgt    = out_tgt_r;
    assign out_wr_en  = out_wr_en_r;
    assign outa       = outa_r;
    assign outb       = outb_r;
    assign out_stdata = out_stdata_r;
    assign out_pc     = out_pc_r;

endmodule

// File: tb/tb_risc_id_stage.sv
module tb_risc_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [2:0]  src1_addr, src2_addr;
    logic [15:0] src1, src2;
    logic        fwd_ex_en, fwd_mem_en, fwd_wb_en;
    logic [2:0]  fwd_ex_addr, fwd_mem_addr, fwd_wb_addr;
    logic [15:0] fwd_ex_data, fwd_mem_data, fwd_wb_data;
    logic        ex_stall, flush;
    logic        out_valid;
    logic [2:0]  out_op;
    logic [2:0]  out_tgt;
    logic        out_wr_en;
    logic [15:0] outa, outb, out_stdata, out_pc;

    int passed = 0;
    int total  = 0;

    risc_id_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .src1_addr(src1_addr), .src2_addr(src2_addr),
        .src1(src1), .src2(src2),
        .fwd_ex_en(fwd_ex_en), .fwd_mem_en(fwd_mem_en), .fwd_wb_en(fwd_wb_en),
        .fwd_ex_addr(fwd_ex_addr), .fwd_mem_addr(fwd_mem_addr), .fwd_wb_addr(fwd_wb_addr),
        .fwd_ex_data(fwd_ex_data), .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
        .ex_stall(ex_stall), .flush(flush),
        .out_valid(out_valid), .out_op(out_op), .out_tgt(out_tgt), .out_wr_en(out_wr_en),
        .outa(outa), .outb(outb), .out_stdata(out_stdata), .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rrr(input logic [2:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic [2:0] c);
        return {op, a, b, 4'b0000, c};
    endfunction

    function automatic logic [15:0] rri(input logic [2:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic [6:0] imm);
        return {op, a, b, imm};
    endfunction

    initial begin
        // Reset with garbage inputs
        rst = 1'b1; in_valid = 1'b1; instr = 16'hB5A3; pc = 16'h1234;
        src1 = 16'hDEAD; src2 = 16'hBEEF;
        fwd_ex_en = 1'b1; fwd_mem_en = 1'b1; fwd_wb_en = 1'b1;
        fwd_ex_addr = 3'd3; fwd_mem_addr = 3'd5; fwd_wb_addr = 3'd7;
        fwd_ex_data = 16'h1111; fwd_mem_data = 16'h2222; fwd_wb_data = 16'h3333;
        ex_stall = 1'b0; flush = 1'b0;
        #2;
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_op", out_op, 0);
        check("rst_tgt", out_tgt, 0);
        check("rst_wr_en", out_wr_en, 0);
        check("rst_outa", outa, 0);
        check("rst_outb", outb, 0);
        check("rst_stdata", out_stdata, 0);
        check("rst_pc", out_pc, 0);

        rst = 1'b0; in_valid = 1'b0;
        fwd_ex_en = 1'b0; fwd_mem_en = 1'b0; fwd_wb_en = 1'b0;

        // ADD r1,r2,r3
        instr = rrr(3'b000, 3'd1, 3'd2, 3'd3); pc = 16'h0100;
        src1 = 16'd5; src2 = 16'd7; in_valid = 1'b1;
        #1;
        check("add_src1_addr", src1_addr, 2);
        check("add_src2_addr", src2_addr, 3);
        check("add_in_ready", in_ready, 1);
        tick();
        check("add_valid", out_valid, 1);
        check("add_outa", outa, 5);
        check("add_outb", outb, 7);
        check("add_wr_en", out_wr_en, 1);
        check("add_tgt", out_tgt, 1);
        check("add_pc", out_pc, 16'h0100);
        check("add_stdata", out_stdata, 0);

        // LUI r4,0x3FF
        instr = {3'b011, 3'd4, 10'h3FF}; pc = 16'h0101;
        #1;
        check("lui_src2_addr", src2_addr, 4);
        tick();
        check("lui_outa", outa, 16'hFFC0);
        check("lui_outb", outb, 0);
        check("lui_wr_en", out_wr_en, 1);
        check("lui_stdata", out_stdata, 7);

        // Forwarding priority on ADD r1,r2,r2
        instr = rrr(3'b000, 3'd1, 3'd2, 3'd2); pc = 16'h0102;
        src1 = 16'h0055; src2 = 16'h0055;
        fwd_ex_en = 1'b1; fwd_ex_addr = 3'd2; fwd_ex_data = 16'h0011;
        fwd_mem_en = 1'b1; fwd_mem_addr = 3'd2; fwd_mem_data = 16'h0022;
        fwd_wb_en = 1'b1; fwd_wb_addr = 3'd2; fwd_wb_data = 16'h0033;
        tick();
        check("fwd_ex_outa", outa, 16'h0011);
        check("fwd_ex_outb", outb, 16'h0011);
        fwd_ex_en = 1'b0;
        tick();
        check("fwd_mem_outa", outa, 16'h0022);
        check("fwd_mem_outb", outb, 16'h0022);
        fwd_mem_en = 1'b0;
        tick();
        check("fwd_wb_outa", outa, 16'h0033);
        // r0 reads are zero despite matching forwards
        instr = rrr(3'b000, 3'd1, 3'd0, 3'd0);
        fwd_ex_en = 1'b1; fwd_mem_en = 1'b1; fwd_wb_en = 1'b1;
        fwd_ex_addr = 3'd0; fwd_mem_addr = 3'd0; fwd_wb_addr = 3'd0;
        tick();
        check("r0_outa", outa, 0);
        check("r0_outb", outb, 0);
        fwd_ex_en = 1'b0; fwd_mem_en = 1'b0; fwd_wb_en = 1'b0;

        // Load-use: LW r3,r1,4 then ADDI r5,r3,1
        instr = rri(3'b101, 3'd3, 3'd1, 7'd4); pc = 16'h0200; src1 = 16'h0010;
        tick();
        check("lw_op", out_op, 5);
        check("lw_outa", outa, 16'h0010);
        check("lw_outb", outb, 4);
        instr = rri(3'b001, 3'd5, 3'd3, 7'd1); pc = 16'h0201;
        #1;
        check("hz_in_ready", in_ready, 0);
        tick();
        check("hz_bubble_valid", out_valid, 0);
        check("hz_bubble_wr_en", out_wr_en, 0);
        fwd_mem_en = 1'b1; fwd_mem_addr = 3'd3; fwd_mem_data = 16'hABCD;
        #1;
        check("hz_release_ready", in_ready, 1);
        tick();
        check("hz_issue_valid", out_valid, 1);
        check("hz_issue_op", out_op, 1);
        check("hz_issue_outa", outa, 16'hABCD);
        check("hz_issue_outb", outb, 1);
        check("hz_issue_pc", out_pc, 16'h0201);
        fwd_mem_en = 1'b0;

        // LW r3 then LW r5,r0,0: no dependency
        instr = rri(3'b101, 3'd3, 3'd1, 7'd4); pc = 16'h0300;
        tick();
        instr = rri(3'b101, 3'd5, 3'd0, 7'd0); pc = 16'h0301;
        #1;
        check("nohz_in_ready", in_ready, 1);
        tick();
        check("nohz_valid", out_valid, 1);
        check("nohz_tgt", out_tgt, 5);
        check("nohz_pc", out_pc, 16'h0301);

        // ex_stall held for 3 cycles
        instr = rrr(3'b000, 3'd1, 3'd2, 3'd3); pc = 16'h0400; src1 = 16'd5; src2 = 16'd7;
        tick();
        instr = rrr(3'b010, 3'd2, 3'd3, 3'd4); pc = 16'h0401; src1 = 16'd9; src2 = 16'd3;
        ex_stall = 1'b1;
        #1;
        check("stall_in_ready", in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold_op", out_op, 0);
            check("stall_hold_outa", outa, 5);
            check("stall_hold_pc", out_pc, 16'h0400);
        end
        ex_stall = 1'b0;
        tick();
        check("stall_next_op", out_op, 2);
        check("stall_next_outa", outa, 9);
        check("stall_next_outb", outb, 3);
        check("stall_next_pc", out_pc, 16'h0401);
        in_valid = 1'b0;
        tick();
        check("stall_no_dup", out_valid, 0);

        // Flush coinciding with a hazard
        in_valid = 1'b1; instr = rri(3'b101, 3'd3, 3'd1, 7'd4); pc = 16'h0500;
        tick();
        instr = rri(3'b001, 3'd5, 3'd3, 7'd1); pc = 16'h0501; flush = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 0);
        tick();
        check("flush_valid", out_valid, 0);
        check("flush_wr_en", out_wr_en, 0);
        flush = 1'b0; in_valid = 1'b0;
        tick();
        check("flush_no_reissue", out_valid, 0);

        // Reset mid-stream discards the held instruction
        in_valid = 1'b1; instr = rrr(3'b000, 3'd1, 3'd2, 3'd3); pc = 16'h0600;
        tick();
        check("mid_valid", out_valid, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_pc", out_pc, 0);
        rst = 1'b0; in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/risc_id_stage.md
# risc_id_stage

Pipelined, parametrised successor to the combinational RiSC-16 instruction decode stage. It decodes the opcode internally, so the mux selects for the second source address and both operands are no longer external inputs. It resolves operands with EX/MEM/WB forwarding, detects load-use hazards, and registers the result into an ID/EX pipeline register with valid/stall/flush control. It sits between the fetch stage and EX in the pipelined core.

## Interface
Parameters:
- WORD_LEN, 16, datapath width; must be ≥ 16. The instruction is always 16 bits in RiSC-16 field layout.
- REG_ADDR_LEN, 3, register address width. Fields sit at instr[12:10] (A), [9:7] (B), [2:0] (C); values above 3 bits are not supported.
- PC_LEN, 16, width of the PC passthrough.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  ID accepts the instruction this cycle
- instr  in  16  instruction word
- pc  in  PC_LEN  PC of instr
- src1_addr / src2_addr  out  REG_ADDR_LEN  register-file read addresses (combinational)
- src1 / src2  in  WORD_LEN  register-file read data
- fwd_ex_en, fwd_mem_en, fwd_wb_en  in  1  forwarding source holds a valid write
- fwd_ex_addr, fwd_mem_addr, fwd_wb_addr  in  REG_ADDR_LEN  forwarded destination register
- fwd_ex_data, fwd_mem_data, fwd_wb_data  in  WORD_LEN  forwarded value
- ex_stall  in  1  EX cannot accept; hold the ID/EX register
- flush  in  1  squash the instruction in ID (branch/jump redirect)
- out_valid  out  1  ID/EX register holds a live instruction
- out_op  out  3  opcode
- out_tgt  out  REG_ADDR_LEN  regA
- out_wr_en  out  1  instruction writes the register file
- outa, outb  out  WORD_LEN  EX operands
- out_stdata  out  WORD_LEN  regA value, used by SW and BEQ
- out_pc  out  PC_LEN  PC passthrough

## Operation
- Opcode instr[15:13]: ADD 000, ADDI 001, NAND 010, LUI 011, SW 100, LW 101, BEQ 110, JALR 111.
- src1_addr = regB. src2_addr = regC for ADD/NAND, otherwise regA.
- sig_imm = instr[6:0] sign-extended to WORD_LEN.
- lui_imm = instr[9:0] << (WORD_LEN-10).
- Operand resolution for each read port:
  - Address 0 → 0.
  - Otherwise priority EX > MEM > WB. A stage matches when its _en is set and its _addr equals the read address.
  - No match → register-file data.
  - Resolved values: r1 (port 1), r2 (port 2).
- outa = lui_imm for LUI, else r1.
- outb = r2 for ADD/NAND/BEQ; sig_imm for ADDI/SW/LW; 0 for LUI/JALR.
- out_stdata = r2 when src2_addr = regA, else 0.
- out_wr_en = (op ∈ {ADD, ADDI, NAND, LUI, LW, JALR}) && regA ≠ 0.
- Load-use hazard:
  - Condition: out_valid && out_op = LW && out_tgt ≠ 0 && in_valid.
  - Triggers when out_tgt equals a source the decoded op uses:
    - regB for all ops except LUI;
    - regC for ADD/NAND;
    - regA for SW/BEQ.
- in_ready = !ex_stall && !hazard && !flush.
- ID/EX register update, in priority order:
  1. rst: all outputs 0, out_valid = 0.
  2. ex_stall: hold every output, regardless of flush.
  3. flush: out_valid = 0; other fields don't-care.
  4. hazard or !in_valid: bubble. out_valid = 0, out_wr_en = 0.
  5. Otherwise load the decoded fields, out_valid = 1.
- Bubbles always carry out_wr_en = 0.

## Timing
- Latency: 1 cycle from accept (in_valid && in_ready) to out_valid.
- Combinational outputs: src1_addr/src2_addr from instr; in_ready from instr, the output registers, ex_stall and flush.
- Hazard costs exactly one bubble. On the next cycle the LW is in MEM; fwd_mem supplies the value and in_ready rises.
- Fetch must hold instr/pc stable while in_valid && !in_ready.
- A flush coinciding with a hazard resolves as flush: the instruction is dropped, not retried.
- rst mid-stream discards the held instruction; out_valid = 0 on the cycle after rst.

## Test plan
- Reset: drive rst with garbage inputs → every output 0, out_valid 0, the cycle after rst.
- ADD r1,r2,r3 with src1=5, src2=7, no forwarding → one cycle later out_valid=1, outa=5, outb=7, out_wr_en=1. Then LUI r4,0x3FF with WORD_LEN=16 → outa=0xFFC0.
- Forward priority: ADD r1,r2,r2 with ex=(r2,0x11), mem=(r2,0x22), wb=(r2,0x33) → outa=outb=0x11. Repeat with ex_en=0 → 0x22. Any read of r0 → 0 despite matching forwards.
- Load-use: LW r3,r1,4 then ADDI r5,r3,1 → in_ready=0 for one cycle, one bubble, then ADDI issues with outa=fwd_mem_data. Same pair with the dependent instruction as LW r5,r0,0 → no stall.
- ex_stall held 3 cycles mid-stream → outputs frozen, in_ready=0, no instruction lost or duplicated.
- flush asserted together with a hazard and with ex_stall=0 → next out_valid=0, and the instruction is not re-issued unless fetch re-presents it.
